// File: rtl/pmbus_arbiter.sv
// rtl/pmbus_arbiter.sv - 4-requester round-robin bus arbiter with registered shared-bus mux
// Optional grant-length timeout with preemption when PMARB_TIMEOUT_EN is defined.
module pmbus_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic [3:0] y,
  output logic       y_valid
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  if (HOLD_MAX < 2 || HOLD_MAX > 15) begin : g_hold_range
    $error("HOLD_MAX out of range 2..15");
  end

  logic       state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] y_q, y_d;
  logic       y_valid_q, y_valid_d;
  logic       grant_new;
  logic [3:0] cand;
  logic [3:0] others;
  logic [1:0] win;

  // Scan from farthest to nearest so the first set bit after `last` wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] c, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (c[idx]) rr_pick = idx;
    end
  endfunction

`ifdef PMARB_TIMEOUT_EN
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic       timeout;
  assign timeout = (hold_cnt_q == HOLD_LAST);
`endif

  assign others = req & ~gnt_q;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    grant_new = 1'b0;
    cand      = req;
    win       = 2'd0;
    case (state_q)
      ST_IDLE: begin
        if (|req) grant_new = 1'b1;
      end
      default: begin
        if (!req[sel_q]) begin
          if (|others) begin
            grant_new = 1'b1;
            cand      = others;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
          end
        end
`ifdef PMARB_TIMEOUT_EN
        else if (timeout && |others) begin
          grant_new = 1'b1;
          cand      = others;
        end
`endif
      end
    endcase
    if (grant_new) begin
      win     = rr_pick(cand, ptr_q);
      state_d = ST_GRANT;
      gnt_d   = 4'b0001 << win;
      sel_d   = win;
      ptr_d   = win;
    end
  end

`ifdef PMARB_TIMEOUT_EN
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (grant_new || state_d == ST_IDLE) hold_cnt_d = 4'd0;
    else if (!timeout) hold_cnt_d = hold_cnt_q + 4'd1;
  end
`endif

  // Data path follows the grant registered one edge earlier.
  always_comb begin
    y_d       = 4'h0;
    y_valid_d = 1'b0;
    if (|gnt_q) begin
      y_valid_d = 1'b1;
      case (sel_q)
        2'd0:    y_d = d0;
        2'd1:    y_d = d1;
        2'd2:    y_d = d2;
        default: y_d = d3;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 4'b0000;
      sel_q      <= 2'd0;
      ptr_q      <= 2'd3;
      y_q        <= 4'h0;
      y_valid_q  <= 1'b0;
`ifdef PMARB_TIMEOUT_EN
      hold_cnt_q <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      y_q        <= y_d;
      y_valid_q  <= y_valid_d;
`ifdef PMARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = |gnt_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_pmbus_arbiter.sv
// tb/tb_pmbus_arbiter.sv - scoreboard bench for pmbus_arbiter
module tb_pmbus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic [3:0] y;
  logic       y_valid;

  always #5 clk = ~clk;

  pmbus_arbiter #(.HOLD_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .gnt(gnt), .sel(sel), .busy(busy), .y(y), .y_valid(y_valid)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] y;
    logic       yv;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       e;
  int         passed = 0;
  int         total  = 0;
  logic [3:0] last_g;
  logic [1:0] last_s;

  function automatic logic [3:0] dword(input logic [1:0] s);
    case (s)
      2'd0:    dword = d0;
      2'd1:    dword = d1;
      2'd2:    dword = d2;
      default: dword = d3;
    endcase
  endfunction

  // Expected data is whatever the previously expected owner drove.
  task automatic push_exp(input logic [3:0] g, input logic [1:0] s, input logic in_rst);
    exp_t x;
    x.gnt  = g;
    x.sel  = s;
    x.busy = |g;
    x.yv   = !in_rst && (last_g != 4'b0000);
    x.y    = x.yv ? dword(last_s) : 4'h0;
    last_g = g;
    last_s = s;
    sb_q.push_back(x);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req   = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      push_exp(4'b0000, 2'd0, 1'b1);
      tick();
      e = sb_q.pop_front();
      total++;
      if ({gnt, sel, busy, y, y_valid} !== e)
        $display("FAIL reset cyc%0d got=%h exp=%h", i, {gnt, sel, busy, y, y_valid}, e);
      else passed++;
    end
  endtask

  task automatic test_first_grant;
    rst_n = 1'b1;
    req   = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      push_exp(4'b0001, 2'd0, 1'b0);
      tick();
      e = sb_q.pop_front();
      total++;
      if ({gnt, sel, busy, y, y_valid} !== e)
        $display("FAIL first_grant cyc%0d got=%h exp=%h", i, {gnt, sel, busy, y, y_valid}, e);
      else passed++;
    end
  endtask

  task automatic test_rotation;
    logic [3:0] reqs [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] gnts [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      req = reqs[i];
      push_exp(gnts[i], 2'(i + 1), 1'b0);
      tick();
      e = sb_q.pop_front();
      total++;
      if ({gnt, sel, busy, y, y_valid} !== e)
        $display("FAIL rotation step%0d got=%h exp=%h", i, {gnt, sel, busy, y, y_valid}, e);
      else passed++;
    end
  endtask

  task automatic test_idle;
    logic [3:0] reqs [4] = '{4'b1000, 4'b0000, 4'b0000, 4'b0110};
    logic [3:0] gnts [4] = '{4'b1000, 4'b0000, 4'b0000, 4'b0010};
    logic [1:0] sels [4] = '{2'd3, 2'd3, 2'd3, 2'd1};
    for (int i = 0; i < 4; i++) begin
      req = reqs[i];
      push_exp(gnts[i], sels[i], 1'b0);
      tick();
      e = sb_q.pop_front();
      total++;
      if ({gnt, sel, busy, y, y_valid} !== e)
        $display("FAIL idle step%0d got=%h exp=%h", i, {gnt, sel, busy, y, y_valid}, e);
      else passed++;
    end
  endtask

  task automatic test_hold_single;
    req = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      push_exp(4'b0100, 2'd2, 1'b0);
      tick();
      e = sb_q.pop_front();
      total++;
      if ({gnt, sel, busy, y, y_valid} !== e)
        $display("FAIL hold_single cyc%0d got=%h exp=%h", i, {gnt, sel, busy, y, y_valid}, e);
      else passed++;
    end
  endtask

  task automatic test_timeout;
    logic [3:0] g;
    req = 4'b0011;
    for (int i = 0; i < 24; i++) begin
`ifdef PMARB_TIMEOUT_EN
      g = (((i / 8) % 2) == 0) ? 4'b0001 : 4'b0010;
`else
      g = 4'b0001;
`endif
      push_exp(g, (g == 4'b0010) ? 2'd1 : 2'd0, 1'b0);
      tick();
      e = sb_q.pop_front();
      total++;
      if ({gnt, sel, busy, y, y_valid} !== e)
        $display("FAIL timeout cyc%0d got=%h exp=%h", i, {gnt, sel, busy, y, y_valid}, e);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_grant;
    logic       rsts [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] reqs [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0101, 4'b0101};
    logic [3:0] gnts [5] = '{4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b0001};
    logic [1:0] sels [5] = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd0};
    for (int i = 0; i < 5; i++) begin
      rst_n = rsts[i];
      req   = reqs[i];
      push_exp(gnts[i], sels[i], !rsts[i]);
      tick();
      e = sb_q.pop_front();
      total++;
      if ({gnt, sel, busy, y, y_valid} !== e)
        $display("FAIL reset_mid step%0d got=%h exp=%h", i, {gnt, sel, busy, y, y_valid}, e);
      else passed++;
    end
  endtask

  initial begin
    d0 = 4'h5;
    d1 = 4'h6;
    d2 = 4'hA;
    d3 = 4'hC;
    rst_n  = 1'b0;
    req    = 4'b0000;
    last_g = 4'b0000;
    last_s = 2'd0;
    #2;
    test_reset();
    test_first_grant();
    test_rotation();
    test_idle();
    test_hold_single();
    test_timeout();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
